// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-cache requests, holds the pipeline on misses,
// tracks the LL/SC link and registers the MEM/WB result.
`timescale 1ns/1ps

module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic        ex_ll,
  input  logic        ex_sc,
  input  logic        ex_RegWEN,
  input  logic        ex_MemtoReg,
  input  logic        ex_halt,
  input  logic [4:0]  ex_wsel,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store,
  input  logic [31:0] ex_result,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_RegWEN,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_wdat,
  output logic        wb_halt,
  output logic [15:0] wait_cnt
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic        req_ren_q, req_ren_d;
  logic        req_wen_q, req_wen_d;
  logic        req_ll_q, req_ll_d;
  logic        req_sc_q, req_sc_d;
  logic        req_regwen_q, req_regwen_d;
  logic        req_m2r_q, req_m2r_d;
  logic        req_halt_q, req_halt_d;
  logic [4:0]  req_wsel_q, req_wsel_d;
  logic [29:0] req_waddr_q, req_waddr_d;
  logic [31:0] req_store_q, req_store_d;
  logic [31:0] req_result_q, req_result_d;
  logic        link_valid_q, link_valid_d;
  logic [29:0] link_addr_q, link_addr_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwen_q, wb_regwen_d;
  logic [4:0]  wb_wsel_q, wb_wsel_d;
  logic [31:0] wb_wdat_q, wb_wdat_d;
  logic        wb_halt_q, wb_halt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic accept, is_mem, sc_ok, sc_fail, mem_op, alu_op, stall_raw;
  logic unused_addr_bits;

  assign unused_addr_bits = ^ex_addr[1:0];

  // Nothing new is accepted while in reset or after a halt has retired.
  assign accept  = ex_valid & ~wb_halt_q & ~RST;
  assign is_mem  = ex_dREN | ex_dWEN;
  assign sc_ok   = link_valid_q & (link_addr_q == ex_addr[31:2]);
  assign sc_fail = ex_sc & ~sc_ok;
  assign mem_op  = accept & is_mem & ~sc_fail;
  assign alu_op  = accept & (~is_mem | sc_fail);

  always_comb begin
    state_d      = state_q;
    req_ren_d    = req_ren_q;
    req_wen_d    = req_wen_q;
    req_ll_d     = req_ll_q;
    req_sc_d     = req_sc_q;
    req_regwen_d = req_regwen_q;
    req_m2r_d    = req_m2r_q;
    req_halt_d   = req_halt_q;
    req_wsel_d   = req_wsel_q;
    req_waddr_d  = req_waddr_q;
    req_store_d  = req_store_q;
    req_result_d = req_result_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    wb_valid_d   = 1'b0;
    wb_regwen_d  = 1'b0;
    wb_wsel_d    = 5'd0;
    wb_wdat_d    = 32'd0;
    wb_halt_d    = wb_halt_q;
    stall_raw    = 1'b0;
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    dmemaddr     = 32'd0;
    dmemstore    = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          state_d      = StAccess;
          stall_raw    = 1'b1;
          req_ren_d    = ex_dREN & ~ex_dWEN;
          req_wen_d    = ex_dWEN;
          req_ll_d     = ex_ll;
          req_sc_d     = ex_sc;
          req_regwen_d = ex_RegWEN;
          req_m2r_d    = ex_MemtoReg;
          req_halt_d   = ex_halt;
          req_wsel_d   = ex_wsel;
          req_waddr_d  = ex_addr[31:2];
          req_store_d  = ex_store;
          req_result_d = ex_result;
        end else if (alu_op) begin
          wb_valid_d  = 1'b1;
          wb_regwen_d = ex_RegWEN;
          wb_wsel_d   = ex_wsel;
          wb_wdat_d   = sc_fail ? 32'd0 : ex_result;
          wb_halt_d   = wb_halt_q | ex_halt;
        end
      end
      StAccess: begin
        dmemREN   = req_ren_q;
        dmemWEN   = req_wen_q;
        dmemaddr  = {req_waddr_q, 2'b00};
        dmemstore = req_store_q;
        if (dhit) begin
          state_d     = StIdle;
          wb_valid_d  = 1'b1;
          // Plain stores never write the register file; SC writes its status.
          wb_regwen_d = req_regwen_q & (~req_wen_q | req_sc_q);
          wb_wsel_d   = req_wsel_q;
          wb_halt_d   = wb_halt_q | req_halt_q;
          if (req_sc_q)                   wb_wdat_d = 32'd1;
          else if (req_ren_q & req_m2r_q) wb_wdat_d = dmemload;
          else                            wb_wdat_d = req_result_q;
          if (req_wen_q && req_waddr_q == link_addr_q) link_valid_d = 1'b0;
          if (req_ren_q && req_ll_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = req_waddr_q;
          end
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    mem_stall  = stall_raw & ~RST;
    wait_cnt_d = (mem_stall && wait_cnt_q != 16'hFFFF) ? wait_cnt_q + 16'd1 : wait_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      req_ren_q    <= 1'b0;
      req_wen_q    <= 1'b0;
      req_ll_q     <= 1'b0;
      req_sc_q     <= 1'b0;
      req_regwen_q <= 1'b0;
      req_m2r_q    <= 1'b0;
      req_halt_q   <= 1'b0;
      req_wsel_q   <= 5'd0;
      req_waddr_q  <= 30'd0;
      req_store_q  <= 32'd0;
      req_result_q <= 32'd0;
      link_valid_q <= 1'b0;
      link_addr_q  <= 30'd0;
      wb_valid_q   <= 1'b0;
      wb_regwen_q  <= 1'b0;
      wb_wsel_q    <= 5'd0;
      wb_wdat_q    <= 32'd0;
      wb_halt_q    <= 1'b0;
      wait_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      req_ren_q    <= req_ren_d;
      req_wen_q    <= req_wen_d;
      req_ll_q     <= req_ll_d;
      req_sc_q     <= req_sc_d;
      req_regwen_q <= req_regwen_d;
      req_m2r_q    <= req_m2r_d;
      req_halt_q   <= req_halt_d;
      req_wsel_q   <= req_wsel_d;
      req_waddr_q  <= req_waddr_d;
      req_store_q  <= req_store_d;
      req_result_q <= req_result_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_regwen_q  <= wb_regwen_d;
      wb_wsel_q    <= wb_wsel_d;
      wb_wdat_q    <= wb_wdat_d;
      wb_halt_q    <= wb_halt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_RegWEN = wb_regwen_q;
  assign wb_wsel   = wb_wsel_q;
  assign wb_wdat   = wb_wdat_q;
  assign wb_halt   = wb_halt_q;
  assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed ops, expected MEM/WB results queued at issue and
// popped by a monitor whenever wb_valid is seen.
`timescale 1ns/1ps

module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc, ex_RegWEN, ex_MemtoReg, ex_halt;
  logic [4:0]  ex_wsel;
  logic [31:0] ex_addr, ex_store, ex_result;
  logic        dmemREN, dmemWEN, dhit, mem_stall;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        wb_valid, wb_RegWEN, wb_halt;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic [15:0] wait_cnt;

  mem_stage dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_ll(ex_ll), .ex_sc(ex_sc),
    .ex_RegWEN(ex_RegWEN), .ex_MemtoReg(ex_MemtoReg), .ex_halt(ex_halt), .ex_wsel(ex_wsel),
    .ex_addr(ex_addr), .ex_store(ex_store), .ex_result(ex_result),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_RegWEN(wb_RegWEN), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .wb_halt(wb_halt), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        regwen;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every retired op must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (started) begin
      if (wb_valid === 1'b1) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_wsel", {27'd0, wb_wsel}, {27'd0, e.wsel});
          check("wb_wdat", wb_wdat, e.wdat);
          check("wb_RegWEN", {31'd0, wb_RegWEN}, {31'd0, e.regwen});
          check("wb_halt", {31'd0, wb_halt}, {31'd0, e.halt});
        end
      end else begin
        check("bubble_wdat", wb_wdat, 32'd0);
        check("bubble_ctl", {26'd0, wb_RegWEN, wb_wsel}, 32'd0);
      end
    end
  end

  task automatic set_op(input logic ren, input logic wen, input logic ll, input logic sc,
                        input logic regwen, input logic m2r, input logic halt,
                        input logic [4:0] wsel, input logic [31:0] addr,
                        input logic [31:0] store, input logic [31:0] result);
    ex_valid = 1'b1; ex_dREN = ren; ex_dWEN = wen; ex_ll = ll; ex_sc = sc;
    ex_RegWEN = regwen; ex_MemtoReg = m2r; ex_halt = halt; ex_wsel = wsel;
    ex_addr = addr; ex_store = store; ex_result = result;
  endtask

  task automatic clr_op();
    ex_valid = 1'b0; ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_ll = 1'b0; ex_sc = 1'b0;
    ex_RegWEN = 1'b0; ex_MemtoReg = 1'b0; ex_halt = 1'b0; ex_wsel = 5'd0;
    ex_addr = 32'd0; ex_store = 32'd0; ex_result = 32'd0;
  endtask

  function automatic exp_t mk(input logic [4:0] wsel, input logic [31:0] wdat,
                              input logic regwen, input logic halt);
    exp_t e;
    e.wsel = wsel; e.wdat = wdat; e.regwen = regwen; e.halt = halt;
    return e;
  endfunction

  // Called at posedge+1 with the op on ex_*; dhit arrives on ACCESS cycle number lat.
  task automatic mem_access(input string name, input int lat, input logic [31:0] load,
                            input logic exp_wen, input logic [31:0] exp_addr,
                            input logic [31:0] exp_store, output int stalls);
    stalls = 0;
    @(negedge CLK);
    check({name, "_stall_idle"}, {31'd0, mem_stall}, 32'd1);
    if (mem_stall === 1'b1) stalls++;
    for (int i = 0; i <= lat; i++) begin
      @(posedge CLK); #1;
      dhit = (i == lat); dmemload = load;
      @(negedge CLK);
      check({name, "_ren"}, {31'd0, dmemREN}, {31'd0, ~exp_wen});
      check({name, "_wen"}, {31'd0, dmemWEN}, {31'd0, exp_wen});
      check({name, "_addr"}, dmemaddr, exp_addr);
      if (exp_wen) check({name, "_store"}, dmemstore, exp_store);
      if (mem_stall === 1'b1) stalls++;
    end
    @(posedge CLK); #1;
    dhit = 1'b0; dmemload = 32'd0;
    clr_op();
  endtask

  // Called at posedge+1 with a non-memory (or failing SC) op on ex_*.
  task automatic alu_step(input string name);
    @(negedge CLK);
    check({name, "_nostall"}, {31'd0, mem_stall}, 32'd0);
    check({name, "_nowen"}, {31'd0, dmemWEN}, 32'd0);
    @(posedge CLK); #1;
    clr_op();
  endtask

  int st;

  initial begin
    clr_op();
    dhit = 1'b0; dmemload = 32'd0; RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_dmem", {30'd0, dmemREN, dmemWEN}, 32'd0);
    check("rst_wait_cnt", {16'd0, wait_cnt}, 32'd0);
    check("rst_wb_halt", {31'd0, wb_halt}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    started = 1'b1;

    // ALU op retires one cycle later without stalling.
    set_op(0, 0, 0, 0, 1, 0, 0, 5'd5, 32'd0, 32'd0, 32'h1234);
    exp_q.push_back(mk(5'd5, 32'h1234, 1'b1, 1'b0));
    alu_step("alu");
    @(negedge CLK);
    check("alu_latency", {31'd0, wb_valid}, 32'd1);
    @(posedge CLK); #1;

    // Load with three miss cycles.
    set_op(1, 0, 0, 0, 1, 1, 0, 5'd7, 32'h103, 32'd0, 32'h0);
    exp_q.push_back(mk(5'd7, 32'hDEADBEEF, 1'b1, 1'b0));
    mem_access("ld", 3, 32'hDEADBEEF, 1'b0, 32'h100, 32'd0, st);
    check("ld_stall_cycles", st, 32'd4);
    @(negedge CLK);
    check("ld_wait_cnt", {16'd0, wait_cnt}, 32'd4);
    @(posedge CLK); #1;

    // LL then successful SC, then a second SC that must fail.
    set_op(1, 0, 1, 0, 1, 1, 0, 5'd8, 32'h200, 32'd0, 32'd0);
    exp_q.push_back(mk(5'd8, 32'h55, 1'b1, 1'b0));
    mem_access("ll1", 0, 32'h55, 1'b0, 32'h200, 32'd0, st);
    set_op(0, 1, 0, 1, 1, 0, 0, 5'd9, 32'h200, 32'd7, 32'd0);
    exp_q.push_back(mk(5'd9, 32'd1, 1'b1, 1'b0));
    mem_access("sc_ok", 1, 32'd0, 1'b1, 32'h200, 32'd7, st);
    set_op(0, 1, 0, 1, 1, 0, 0, 5'd9, 32'h200, 32'd7, 32'd0);
    exp_q.push_back(mk(5'd9, 32'd0, 1'b1, 1'b0));
    alu_step("sc_again");

    // LL, plain store to the linked word, then SC must fail.
    set_op(1, 0, 1, 0, 1, 1, 0, 5'd10, 32'h200, 32'd0, 32'd0);
    exp_q.push_back(mk(5'd10, 32'h66, 1'b1, 1'b0));
    mem_access("ll2", 0, 32'h66, 1'b0, 32'h200, 32'd0, st);
    set_op(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h200, 32'h5A, 32'd0);
    exp_q.push_back(mk(5'd0, 32'd0, 1'b0, 1'b0));
    mem_access("sw", 0, 32'd0, 1'b1, 32'h200, 32'h5A, st);
    set_op(0, 1, 0, 1, 1, 0, 0, 5'd11, 32'h200, 32'd9, 32'd0);
    exp_q.push_back(mk(5'd11, 32'd0, 1'b1, 1'b0));
    alu_step("sc_broken");

    // Read+write both set: write only.
    set_op(1, 1, 0, 0, 0, 0, 0, 5'd0, 32'h302, 32'h77, 32'd0);
    exp_q.push_back(mk(5'd0, 32'd0, 1'b0, 1'b0));
    mem_access("rw", 0, 32'd0, 1'b1, 32'h300, 32'h77, st);

    // Reset mid-ACCESS with a hit in the same cycle.
    set_op(1, 0, 0, 0, 1, 1, 0, 5'd12, 32'h400, 32'd0, 32'd0);
    @(negedge CLK);
    check("rst_ld_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst_ld_ren", {31'd0, dmemREN}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1; dhit = 1'b1; dmemload = 32'h999;
    @(negedge CLK);
    check("rst_cycle_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; dhit = 1'b0; dmemload = 32'd0;
    clr_op();
    @(negedge CLK);
    check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("post_rst_dmem", {30'd0, dmemREN, dmemWEN}, 32'd0);
    check("post_rst_addr", dmemaddr, 32'd0);
    check("post_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("post_rst_wait_cnt", {16'd0, wait_cnt}, 32'd0);

    // A memory op presented during reset is not accepted.
    @(posedge CLK); #1;
    RST = 1'b1;
    set_op(1, 0, 0, 0, 1, 1, 0, 5'd13, 32'h404, 32'd0, 32'd0);
    @(negedge CLK);
    check("rst_op_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    clr_op();
    @(negedge CLK);
    check("rst_op_ren", {31'd0, dmemREN}, 32'd0);
    @(posedge CLK); #1;

    // Halt is sticky and blocks later requests.
    set_op(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'd0, 32'd0, 32'd0);
    exp_q.push_back(mk(5'd0, 32'd0, 1'b0, 1'b1));
    alu_step("halt");
    @(negedge CLK);
    check("halt_set", {31'd0, wb_halt}, 32'd1);
    @(posedge CLK); #1;
    set_op(1, 0, 0, 0, 1, 1, 0, 5'd14, 32'h500, 32'd0, 32'd0);
    @(negedge CLK);
    check("halt_ld_ren", {31'd0, dmemREN}, 32'd0);
    check("halt_ld_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("halt_ld_ren2", {31'd0, dmemREN}, 32'd0);
    check("halt_sticky", {31'd0, wb_halt}, 32'd1);
    check("halt_no_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge CLK); #1;
    clr_op();

    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: CLK in 1, pipeline clock, all state updates on rising edge.
REQ-002 SHALL have: RST in 1, reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have: ex_valid in 1, ex_dREN in 1, ex_dWEN in 1, ex_ll in 1, ex_sc in 1, ex_RegWEN in 1, ex_MemtoReg in 1, ex_halt in 1, ex_wsel in 5, ex_addr in 32, ex_store in 32, ex_result in 32; this is the EX-stage bundle from the EX/MEM latch.
REQ-004 SHALL have: dmemREN out 1, dmemWEN out 1, dmemaddr out 32, dmemstore out 32, dhit in 1, dmemload in 32; this is the data-cache request port.
REQ-005 SHALL have: mem_stall out 1, high = upstream latches (IF/ID, ID/EX, EX/MEM) hold.
REQ-006 SHALL have: wb_valid out 1, wb_RegWEN out 1, wb_wsel out 5, wb_wdat out 32, wb_halt out 1; these are the registered MEM/WB outputs.
REQ-007 SHALL have: wait_cnt out 16, saturating count of stalled cycles.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS.
REQ-009 SHALL treat a memory op as ex_valid & (ex_dREN | ex_dWEN), excluding an SC that fails per REQ-015.
- IDLE with memory op: capture request, mem_stall=1, go to ACCESS.
- Else: stay IDLE.
REQ-010 SHALL, in ACCESS, drive dmemREN/dmemWEN from the captured request, plus dmemaddr={addr[31:2],2'b00} and dmemstore=captured ex_store; these outputs SHALL be 0 in IDLE.
REQ-011 SHALL, in ACCESS with dhit=0, hold mem_stall=1 and stay in ACCESS.
- With dhit=1: set mem_stall=0, update MEM/WB on that edge, return to IDLE.
- Minimum memory-op latency is 2 cycles.
REQ-012 SHALL, for a valid non-memory op in IDLE, update MEM/WB at the next edge with mem_stall=0.
- wb_wdat=ex_result.
- Latency is 1 cycle.
REQ-013 SHALL select wb_wdat=dmemload for loads (MemtoReg=1); for stores, wb_RegWEN SHALL be 0.
REQ-014 SHALL give ex_dWEN priority when ex_dREN and ex_dWEN are both set, issuing a write only.
REQ-015 SHALL keep link_valid (1 bit) and link_addr (30 bits, word address).
- LL completion sets both.
- Any completed write to link_addr clears link_valid.
- SC succeeds only if link_valid and the addr matches; it then writes and sets wb_wdat=1.
- Failed SC: no cache request, no stall, wb_wdat=0, RegWEN held.
- Successful SC completion clears link_valid.
REQ-016 SHALL set wb_valid=0 and all wb_* to 0 on any edge where no op completes (bubble or ex_valid=0).
REQ-017 SHALL set wb_halt sticky once a halt op completes.
- After that, no further cache requests are issued and wb_valid stays 0.
REQ-018 SHALL increment wait_cnt each cycle mem_stall=1, saturating at 16'hFFFF.

Reset
REQ-019 SHALL, with RST=1 at an edge, perform all of the following:
- FSM to IDLE.
- dmem* outputs, mem_stall, and all wb_* outputs to 0.
- link_valid=0, wait_cnt=0.
REQ-020 SHALL abort an in-flight ACCESS on reset, with no MEM/WB update; a dhit arriving in the reset cycle SHALL be ignored.
REQ-021 SHALL accept no op during a cycle with RST=1.

Verification
REQ-022 SHALL cover: ALU op ex_result=0x1234, wsel=5, RegWEN=1 -> next cycle wb_valid=1, wb_wdat=0x1234, mem_stall never 1.
REQ-023 SHALL cover: load addr=0x103, dhit after 3 ACCESS cycles, dmemload=0xDEADBEEF.
- dmemaddr=0x100.
- mem_stall=1 for 4 cycles.
- wb_wdat=0xDEADBEEF.
- wait_cnt=4.
REQ-024 SHALL cover: LL 0x200, then SC 0x200 store=7 -> write issued, wb_wdat=1; second SC 0x200 -> no request, wb_wdat=0.
REQ-025 SHALL cover: LL 0x200, SW 0x200, SC 0x200 -> SC fails, dmemWEN never asserted for SC.
REQ-026 SHALL cover: RST=1 mid-ACCESS with dhit=1 same cycle -> IDLE, wb_valid=0, all outputs 0.
REQ-027 SHALL cover: halt op completes -> wb_halt=1 persists; subsequent load issues no dmemREN.
